vnp4_pkt_size_annotator: RTL and testbench
==========================================

# vnp4_pkt_size_annotator

Store-and-forward ingress stage that converts a plain 512-bit AXI-Stream packet stream into the VNP4 user-plugin stream (axi_stream_vnp4_if). A VNP4 pipeline needs the packet byte length on the first beat, so each packet is buffered whole. Its byte size is counted, and the packet is then replayed with user_size and port metadata attached. Packets longer than the buffer are dropped and counted.

## Interface
- DATA_DEPTH, 256: data buffer depth in beats; power of 2, at least 4; largest accepted packet.
- DESC_DEPTH, 32: descriptor FIFO depth in packets; power of 2.
- EGRESS_DEFAULT, 9'd0: constant driven on user_egress_port.
- axis_aclk  in  1  clock; single clock domain.
- axis_rst  in  1  synchronous, active-high reset.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tdata  in  512  input data.
- s_axis_tkeep  in  64  byte enables; contiguous from bit 0.
- s_axis_tlast  in  1  last beat of packet.
- s_axis_tready  out  1  input ready.
- ingress_port  in  9  port id; sampled on each packet's first accepted beat.
- m_axis  axi_stream_vnp4_if.master  output stream.
- drop_count  out  32  count of dropped oversize packets; wraps.

## Operation
- Write side FSM states:
  - IDLE: no packet in progress.
  - WRITE: packet in progress.
  - DROP: discarding the rest of an oversize packet.
- Accept: a beat is accepted when s_axis_tvalid and s_axis_tready are both high.
  - IDLE goes to WRITE on an accepted non-last beat.
  - A single-beat packet (tlast on first beat) stays in IDLE and commits immediately.
- Byte count per beat is popcount(tkeep), 0..64. A 17-bit accumulator sums bytes over the packet. user_size is the low 16 bits; the maximum is 256 beats x 64 = 16384, so no overflow.
- Data buffer entries hold {tdata, tkeep, tlast}.
  - Write pointer wr_ptr advances on every accepted beat.
  - Committed pointer wr_commit is the only pointer visible to the reader.
- Commit on an accepted tlast beat in IDLE or WRITE:
  - wr_commit <= wr_ptr+1.
  - Push {size, ingress_port} into the descriptor FIFO.
  - Return to IDLE.
- Oversize: an accepted non-last beat that would be beat number DATA_DEPTH of the packet, with no tlast:
  - Rewind wr_ptr to wr_commit.
  - Enter DROP.
- DROP: s_axis_tready=1; beats are discarded. On the accepted tlast beat, increment drop_count and go to IDLE. No descriptor is pushed.
- s_axis_tready in IDLE/WRITE = (data buffer not full w.r.t. the read pointer) AND (descriptor FIFO not full).
- Read side, states RD_IDLE and RD_PKT:
  - RD_IDLE pops a descriptor when the FIFO is non-empty, then goes to RD_PKT.
  - RD_PKT streams beats from the read pointer.
  - On the handshake of a beat with last, it pops the next descriptor if one is available (no bubble); otherwise it goes to RD_IDLE.
- Output field mapping:
  - m_axis.data/keep/last come from the buffer.
  - user_size and user_ingress_port come from the current descriptor and are held on every beat.
  - user_egress_port = EGRESS_DEFAULT.
  - user_valid=1 on the first beat of each packet only.
- Zero-byte packet (a single beat with tkeep=0 and tlast): forwarded with user_size=0.

## Timing
- Reset values (the cycle after axis_rst is sampled high):
  - s_axis_tready=0.
  - m_axis.valid=0, user_valid=0; m_axis data/keep/last/size/ports=0.
  - drop_count=0.
  - All pointers 0; both FSMs idle.
- s_axis_tready=1 in the first cycle after reset deasserts.
- Reset mid-packet discards all buffered and partial packets with no output.
- Latency: tlast beat accepted at edge T; m_axis.valid first beat is high in cycle T+2 when the output is idle.
- Throughput: one beat per cycle in and out. Back-to-back committed packets stream with no idle cycle between them.
- m_axis AXI rules:
  - valid, once high, stays high with all fields stable until ready.
  - valid does not depend combinationally on ready.
- Full-buffer boundary: tready drops in the cycle the buffer holds DATA_DEPTH uncommitted-plus-committed beats. It rises the cycle after a read frees an entry.
- Simultaneous commit and final-beat read: descriptor push and pop happen in the same cycle, and the count is unchanged.

## Test plan
- Single 1-beat packet, tkeep=64'hF, ingress_port=5 -> one output beat; user_valid=1, user_size=4, user_ingress_port=5, last=1, at cycle T+2.
- 3-beat packet (keep all-ones, all-ones, 64'h3) with m_axis.ready=1 -> 3 beats; user_size=130; user_valid only on beat 0.
- Two back-to-back 2-beat packets with random m_axis.ready toggling -> data unchanged and in order; no gap between packets when ready=1; sizes correct.
- DATA_DEPTH=4: 6-beat packet followed by a 1-beat packet -> 6-beat packet absent; drop_count=1; the 1-beat packet is emitted correctly.
- m_axis.ready=0 until the buffer fills -> s_axis_tready=0 exactly at DATA_DEPTH beats; after ready=1, all beats are drained intact.
- axis_rst asserted mid-packet with the output stalled -> next cycle all outputs at reset values; a following packet passes correctly.

Source files
------------

// File: rtl/vnp4_pkt_size_annotator_if.sv
// VNP4 user-plugin stream: 512-bit AXI-Stream plus per-packet size/port metadata.
interface axi_stream_vnp4_if;
  logic         valid;
  logic         ready;
  logic [511:0] data;
  logic [63:0]  keep;
  logic         last;
  logic [15:0]  user_size;
  logic [8:0]   user_ingress_port;
  logic [8:0]   user_egress_port;
  logic         user_valid;

  modport master (
    output valid, data, keep, last, user_size, user_ingress_port, user_egress_port, user_valid,
    input  ready
  );
  modport slave (
    input  valid, data, keep, last, user_size, user_ingress_port, user_egress_port, user_valid,
    output ready
  );
endinterface

// File: rtl/vnp4_pkt_size_annotator.sv
// Store-and-forward ingress stage: buffers each packet whole, counts its bytes,
// then replays it on the VNP4 stream with size/port metadata on the first beat.

module vnp4_keep_lane_cnt #(
  parameter int VEC_W = 8,
  parameter int CW    = $clog2(VEC_W + 1)
) (
  input  logic [VEC_W-1:0] keep,
  output logic [CW-1:0]    cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < VEC_W; i++) cnt = cnt + CW'(keep[i]);
  end
endmodule

module vnp4_pkt_size_annotator #(
  parameter int         DATA_DEPTH     = 256,
  parameter int         DESC_DEPTH     = 32,
  parameter logic [8:0] EGRESS_DEFAULT = 9'd0
) (
  input  logic               axis_aclk,
  input  logic               axis_rst,
  input  logic               s_axis_tvalid,
  input  logic [511:0]       s_axis_tdata,
  input  logic [63:0]        s_axis_tkeep,
  input  logic               s_axis_tlast,
  output logic               s_axis_tready,
  input  logic [8:0]         ingress_port,
  axi_stream_vnp4_if.master  m_axis,
  output logic [31:0]        drop_count
);
  localparam int AW        = $clog2(DATA_DEPTH);
  localparam int DW        = $clog2(DESC_DEPTH);
  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 8;
  localparam int CW        = $clog2(VEC_W + 1);
  localparam logic [AW:0] BUF_FULL  = (AW+1)'(DATA_DEPTH);
  localparam logic [AW:0] LAST_IDX  = (AW+1)'(DATA_DEPTH - 1);
  localparam logic [DW:0] DESC_FULL = (DW+1)'(DESC_DEPTH);

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
  } beat_t;

  typedef struct packed {
    logic [15:0] len;
    logic [8:0]  port;
  } desc_t;

  typedef enum logic [1:0] {IDLE, WRITE, DROP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_PKT} rd_state_t;

  beat_t mem   [DATA_DEPTH];
  desc_t dfifo [DESC_DEPTH];

  wr_state_t   wr_st, wr_nxt;
  rd_state_t   rd_st, rd_nxt;
  logic [AW:0] wr_ptr, wr_commit, rd_ptr, beat_cnt;
  logic [DW:0] d_wr, d_rd;
  logic [16:0] size_acc, size_tot;
  logic [8:0]  port_q;
  logic        run_q;
  logic        tready, acc, wr_en, commit, oversize, drop_done;
  logic        buf_full, desc_full, desc_empty;
  logic        pop, load, first_q;
  logic        out_v, out_first;
  beat_t       out_b, rd_beat;
  desc_t       cur, out_d, desc_w;

  // Per-lane byte counts of tkeep, summed into the beat's byte total.
  logic [NUM_LANES-1:0][VEC_W-1:0] keep_lanes;
  logic [NUM_LANES-1:0][CW-1:0]    lane_cnt;
  logic [6:0]                      beat_bytes;

  assign keep_lanes = s_axis_tkeep;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      vnp4_keep_lane_cnt #(.VEC_W(VEC_W), .CW(CW)) u_lane (
        .keep (keep_lanes[g]),
        .cnt  (lane_cnt[g])
      );
    end
  endgenerate

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < NUM_LANES; i++) beat_bytes = beat_bytes + 7'(lane_cnt[i]);
  end

  assign buf_full   = (wr_ptr - rd_ptr) == BUF_FULL;
  assign desc_full  = (d_wr - d_rd) == DESC_FULL;
  assign desc_empty = d_wr == d_rd;
  assign size_tot   = size_acc + 17'(beat_bytes);
  assign desc_w.len  = size_tot[16] ? 16'hFFFF : size_tot[15:0];
  assign desc_w.port = (wr_st == IDLE) ? ingress_port : port_q;

  // ---------------- write side ----------------
  always_ff @(posedge axis_aclk) begin
    if (axis_rst) wr_st <= IDLE;
    else          wr_st <= wr_nxt;
  end

  always_comb begin
    wr_nxt    = wr_st;
    tready    = 1'b0;
    wr_en     = 1'b0;
    commit    = 1'b0;
    oversize  = 1'b0;
    drop_done = 1'b0;
    if (run_q) tready = (wr_st == DROP) ? 1'b1 : (!buf_full && !desc_full);
    acc = s_axis_tvalid && tready;
    case (wr_st)
      IDLE, WRITE: if (acc) begin
        if (s_axis_tlast) begin
          wr_en  = 1'b1;
          commit = 1'b1;
          wr_nxt = IDLE;
        end else if (beat_cnt == LAST_IDX) begin
          oversize = 1'b1;
          wr_nxt   = DROP;
        end else begin
          wr_en  = 1'b1;
          wr_nxt = WRITE;
        end
      end
      DROP: if (acc && s_axis_tlast) begin
        drop_done = 1'b1;
        wr_nxt    = IDLE;
      end
      default: wr_nxt = IDLE;
    endcase
  end

  assign s_axis_tready = tready;

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      run_q      <= 1'b0;
      wr_ptr     <= '0;
      wr_commit  <= '0;
      beat_cnt   <= '0;
      size_acc   <= '0;
      port_q     <= '0;
      d_wr       <= '0;
      drop_count <= '0;
    end else begin
      run_q <= 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (commit) begin
        wr_commit <= wr_ptr + (AW+1)'(1);
        d_wr      <= d_wr + (DW+1)'(1);
        beat_cnt  <= '0;
        size_acc  <= '0;
      end else if (oversize) begin
        // Throw away the partial packet; only committed data stays visible.
        wr_ptr   <= wr_commit;
        beat_cnt <= '0;
        size_acc <= '0;
      end else if (wr_en) begin
        beat_cnt <= beat_cnt + (AW+1)'(1);
        size_acc <= size_tot;
        if (wr_st == IDLE) port_q <= ingress_port;
      end
      if (drop_done) drop_count <= drop_count + 32'd1;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (wr_en)  mem[wr_ptr[AW-1:0]] <= '{data: s_axis_tdata, keep: s_axis_tkeep, last: s_axis_tlast};
    if (commit) dfifo[d_wr[DW-1:0]] <= desc_w;
  end

  // ---------------- read side ----------------
  assign rd_beat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) rd_st <= RD_IDLE;
    else          rd_st <= rd_nxt;
  end

  // Next descriptor is popped as the last beat enters the output register,
  // so the following packet's first beat loads on the very next cycle.
  always_comb begin
    rd_nxt = rd_st;
    pop    = 1'b0;
    load   = 1'b0;
    case (rd_st)
      RD_IDLE: if (!desc_empty) begin
        pop    = 1'b1;
        rd_nxt = RD_PKT;
      end
      RD_PKT: if (!out_v || m_axis.ready) begin
        load = 1'b1;
        if (rd_beat.last) begin
          if (!desc_empty) pop = 1'b1;
          else             rd_nxt = RD_IDLE;
        end
      end
      default: rd_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      rd_ptr    <= '0;
      d_rd      <= '0;
      cur       <= '0;
      first_q   <= 1'b0;
      out_v     <= 1'b0;
      out_first <= 1'b0;
      out_b     <= '0;
      out_d     <= '0;
    end else begin
      if (pop) begin
        cur  <= dfifo[d_rd[DW-1:0]];
        d_rd <= d_rd + (DW+1)'(1);
      end
      if (load) begin
        out_v     <= 1'b1;
        out_b     <= rd_beat;
        out_d     <= cur;
        out_first <= first_q;
        rd_ptr    <= rd_ptr + (AW+1)'(1);
      end else if (m_axis.ready) begin
        out_v <= 1'b0;
      end
      if (pop)       first_q <= 1'b1;
      else if (load) first_q <= 1'b0;
    end
  end

  assign m_axis.valid             = out_v;
  assign m_axis.data              = out_b.data;
  assign m_axis.keep              = out_b.keep;
  assign m_axis.last              = out_b.last;
  assign m_axis.user_size         = out_d.len;
  assign m_axis.user_ingress_port = out_d.port;
  assign m_axis.user_egress_port  = EGRESS_DEFAULT;
  assign m_axis.user_valid        = out_v & out_first;
endmodule

// File: tb/tb_vnp4_pkt_size_annotator.sv
// Bench for vnp4_pkt_size_annotator: packet-level reference model and scoreboard.
module tb_vnp4_pkt_size_annotator;
  localparam int DD = 4;
  localparam int QD = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0;
  logic [511:0] s_data = '0;
  logic [63:0]  s_keep = '0;
  logic         s_last = 1'b0;
  logic         s_ready;
  logic [8:0]   in_port = '0;
  logic [31:0]  drop_count;
  logic         m_ready = 1'b0;

  always #5 clk = ~clk;

  axi_stream_vnp4_if m_if ();
  assign m_if.ready = m_ready;

  vnp4_pkt_size_annotator #(.DATA_DEPTH(DD), .DESC_DEPTH(QD), .EGRESS_DEFAULT(9'd0)) dut (
    .axis_aclk     (clk),
    .axis_rst      (rst),
    .s_axis_tvalid (s_valid),
    .s_axis_tdata  (s_data),
    .s_axis_tkeep  (s_keep),
    .s_axis_tlast  (s_last),
    .s_axis_tready (s_ready),
    .ingress_port  (in_port),
    .m_axis        (m_if),
    .drop_count    (drop_count)
  );

  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    logic [15:0]  size;
    logic [8:0]   port;
    logic         uv;
  } exp_t;

  exp_t         exp_q[$];
  int           n_chk = 0;
  int           n_fail = 0;
  int           exp_drops = 0;
  int           rmode = 0;
  int           pkt_len;
  logic [511:0] pkt_data [16];
  logic [63:0]  pkt_keep [16];

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] keep_of(input int n);
    logic [64:0] k;
    k = (65'd1 << n) - 65'd1;
    return k[63:0];
  endfunction

  function automatic logic [511:0] rnd_data();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Reference model: a packet is either forwarded whole with its byte total, or dropped.
  function automatic void model_commit(input logic [8:0] p);
    int   bytes;
    exp_t e;
    bytes = 0;
    if (pkt_len > DD) begin
      exp_drops++;
      return;
    end
    for (int i = 0; i < pkt_len; i++) bytes += $countones(pkt_keep[i]);
    for (int i = 0; i < pkt_len; i++) begin
      e.data = pkt_data[i];
      e.keep = pkt_keep[i];
      e.last = (i == pkt_len - 1);
      e.size = 16'(bytes);
      e.port = p;
      e.uv   = (i == 0);
      exp_q.push_back(e);
    end
  endfunction

  function automatic void make_pkt(input int len, input bit full_keep);
    pkt_len = len;
    for (int i = 0; i < len; i++) begin
      pkt_data[i] = rnd_data();
      if (full_keep) pkt_keep[i] = '1;
      else if ($urandom_range(0, 3) == 0) pkt_keep[i] = '1;
      else pkt_keep[i] = keep_of($urandom_range(0, 64));
    end
  endfunction

  // Called and returns at posedge+1; returns once the beat has been accepted.
  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l,
                           input logic [8:0] p, output bit ok);
    int w;
    ok = 1'b0;
    s_valid = 1'b1; s_data = d; s_keep = k; s_last = l; in_port = p;
    w = 0;
    while (!s_ready && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    if (!s_ready) begin
      chk("tready_timeout", 0, 1);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    ok = 1'b1;
  endtask

  task automatic send_cur(input logic [8:0] p, input int gap_max);
    bit ok;
    int g;
    for (int i = 0; i < pkt_len; i++) begin
      send_beat(pkt_data[i], pkt_keep[i], logic'(i == pkt_len - 1), p, ok);
      if (!ok) return;
      if (gap_max > 0) begin
        g = $urandom_range(0, gap_max);
        if (g > 0) begin
          s_valid = 1'b0;
          repeat (g) @(posedge clk);
          #1;
        end
      end
    end
    s_valid = 1'b0;
    model_commit(p);
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #2;
    if (rmode == 1) m_ready = 1'($urandom_range(0, 1));
  end

  // Output monitor: scoreboard compare on handshakes, hold check on stalls.
  logic [511:0] hold_d;
  logic [90:0]  hold_m;
  bit           pstall = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) pstall = 1'b0;
    else begin
      if (pstall) begin
        chk("hold_valid", m_if.valid, 1);
        chk("hold_data", m_if.data, hold_d);
        chk("hold_meta", {m_if.keep, m_if.last, m_if.user_size, m_if.user_valid, m_if.user_ingress_port},
            hold_m);
      end
      if (m_if.valid && m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_data", m_if.data, e.data);
          chk("out_keep", m_if.keep, e.keep);
          chk("out_last", m_if.last, e.last);
          chk("out_size", m_if.user_size, e.size);
          chk("out_in_port", m_if.user_ingress_port, e.port);
          chk("out_user_valid", m_if.user_valid, e.uv);
          chk("out_eg_port", m_if.user_egress_port, 0);
        end
      end
      pstall = m_if.valid && !m_ready;
      hold_d = m_if.data;
      hold_m = {m_if.keep, m_if.last, m_if.user_size, m_if.user_valid, m_if.user_ingress_port};
    end
  end

  initial begin
    bit ok;
    int w;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", s_ready, 0);
    chk("rst_valid", m_if.valid, 0);
    chk("rst_user_valid", m_if.user_valid, 0);
    chk("rst_data", m_if.data, 0);
    chk("rst_meta", {m_if.keep, m_if.last, m_if.user_size, m_if.user_ingress_port}, 0);
    chk("rst_drop", drop_count, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("tready_after_rst", s_ready, 1);

    // single 1-beat packet: latency T+2
    m_ready = 1'b1;
    pkt_len = 1; pkt_data[0] = rnd_data(); pkt_keep[0] = 64'hF;
    send_cur(9'd5, 0);
    @(posedge clk); #1;
    chk("lat_t1_valid", m_if.valid, 0);
    @(posedge clk); #1;
    chk("lat_t2_valid", m_if.valid, 1);
    chk("lat_t2_uv", m_if.user_valid, 1);
    chk("lat_t2_size", m_if.user_size, 4);
    chk("lat_t2_port", m_if.user_ingress_port, 5);
    chk("lat_t2_last", m_if.last, 1);
    wait_drain();

    // 3-beat packet, 64+64+2 bytes
    pkt_len = 3;
    for (int i = 0; i < 3; i++) pkt_data[i] = rnd_data();
    pkt_keep[0] = '1; pkt_keep[1] = '1; pkt_keep[2] = 64'h3;
    send_cur(9'd17, 0);
    wait_drain();

    // two back-to-back 2-beat packets: output must be gapless
    fork
      begin
        make_pkt(2, 1'b1); send_cur(9'd33, 0);
        make_pkt(2, 1'b0); send_cur(9'd34, 0);
      end
      begin
        w = 0;
        while (!m_if.valid && w < 30) begin @(negedge clk); w++; end
        for (int k = 0; k < 4; k++) begin
          chk("b2b_no_gap", m_if.valid, 1);
          @(negedge clk);
        end
      end
    join
    wait_drain();

    // same with ready toggling
    rmode = 1;
    make_pkt(2, 1'b0); send_cur(9'd40, 0);
    make_pkt(2, 1'b0); send_cur(9'd41, 0);
    rmode = 0; @(posedge clk); #1; m_ready = 1'b1;
    wait_drain();

    // oversize 6-beat packet then a 1-beat packet
    make_pkt(6, 1'b1); send_cur(9'd50, 0);
    make_pkt(1, 1'b0); send_cur(9'd51, 0);
    wait_drain();
    chk("drop_count_oversize", drop_count, exp_drops);

    // fill the buffer with the output stalled
    m_ready = 1'b0;
    make_pkt(DD, 1'b0);
    for (int i = 0; i < DD; i++) begin
      chk("fill_ready_before_beat", s_ready, 1);
      send_beat(pkt_data[i], pkt_keep[i], logic'(i == DD - 1), 9'd60, ok);
    end
    s_valid = 1'b0;
    model_commit(9'd60);
    chk("fill_full_tready", s_ready, 0);
    @(posedge clk); #1;
    chk("fill_full_tready_hold", s_ready, 0);
    @(posedge clk); #1;
    chk("fill_freed_tready", s_ready, 1);
    m_ready = 1'b1;
    wait_drain();

    // reset mid-packet with the output stalled
    m_ready = 1'b0;
    make_pkt(1, 1'b0); send_cur(9'd70, 0);
    make_pkt(2, 1'b0);
    send_beat(pkt_data[0], pkt_keep[0], 1'b0, 9'd71, ok);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_valid", m_if.valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    exp_drops = 0;
    chk("mid_rst_valid", m_if.valid, 0);
    chk("mid_rst_user_valid", m_if.user_valid, 0);
    chk("mid_rst_data", m_if.data, 0);
    chk("mid_rst_meta", {m_if.keep, m_if.last, m_if.user_size, m_if.user_ingress_port}, 0);
    chk("mid_rst_tready", s_ready, 0);
    chk("mid_rst_drop", drop_count, exp_drops);
    rst = 1'b0;
    @(posedge clk); #1;
    m_ready = 1'b1;
    make_pkt(2, 1'b0); send_cur(9'd72, 0);
    wait_drain();

    // randomized traffic, including zero-byte and oversize packets
    rmode = 1;
    for (int n = 0; n < 40; n++) begin
      make_pkt($urandom_range(1, 6), 1'b0);
      send_cur(9'($urandom_range(0, 511)), $urandom_range(0, 2));
    end
    rmode = 0; @(posedge clk); #1; m_ready = 1'b1;
    wait_drain();
    chk("drop_count_random", drop_count, exp_drops);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
